// File: rtl/top_cpu.sv
// Minimal 8-bit CPU core: a two-state control FSM drives an operand stage and a registered ALU writeback stage.
// Optional feature: define TOP_CPU_SRA_EN to make opcode 1000 an arithmetic shift right instead of illegal.
module top_cpu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [3:0]       instr,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             neg,
   output logic             carry,
   output logic             ovf
);

   typedef enum logic {IDLE, RUN} state_e;

   state_e           state_q, state_d;
   logic             load_en, wb_en;

   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;

   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d, neg_q, neg_d, carry_q, carry_d, ovf_q, ovf_d;

   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_v;
   logic [WIDTH:0]   sum9;

   // rstn is active-high despite its name
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      load_en = 1'b0;
      wb_en   = 1'b0;
      if (state_q == RUN) begin
         load_en = 1'b1;
         wb_en   = 1'b1;
      end
   end

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      sum9    = '0;
      case (op_q)
         4'h0: begin
            sum9    = {1'b0, a_q} + {1'b0, b_q};
            alu_res = sum9[WIDTH-1:0];
            alu_c   = sum9[WIDTH];
            alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
         end
         4'h1: begin
            sum9    = {1'b0, a_q} - {1'b0, b_q};
            alu_res = sum9[WIDTH-1:0];
            alu_c   = sum9[WIDTH];
            alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
         end
         4'h2: alu_res = a_q & b_q;
         4'h3: alu_res = a_q | b_q;
         4'h4: alu_res = a_q ^ b_q;
         4'h5: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
         4'h6: alu_res = a_q << b_q[2:0];
         4'h7: alu_res = a_q >> b_q[2:0];
`ifdef TOP_CPU_SRA_EN
         4'h8: alu_res = $signed(a_q) >>> b_q[2:0];
`endif
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      op_d     = load_en ? instr : op_q;
      a_d      = load_en ? inA : a_q;
      b_d      = load_en ? inB : b_q;
      result_d = wb_en ? alu_res : result_q;
      zero_d   = wb_en ? (alu_res == '0) : zero_q;
      neg_d    = wb_en ? alu_res[WIDTH-1] : neg_q;
      carry_d  = wb_en ? alu_c : carry_q;
      ovf_d    = wb_en ? alu_v : ovf_q;
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         neg_q    <= neg_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
      end
   end

   assign result = result_q;
   assign zero   = zero_q;
   assign neg    = neg_q;
   assign carry  = carry_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_top_cpu.sv
// Scoreboard bench for top_cpu: stimulus pushes expected results, a monitor pops them two edges later.
module tb_top_cpu;

   logic       clk;
   logic       rstn;
   logic [3:0] instr;
   logic [7:0] inA, inB;
   logic [7:0] result;
   logic       zero, neg, carry, ovf;

   typedef struct packed {
      logic [7:0] res;
      logic       z;
      logic       n;
      logic       c;
      logic       v;
   } exp_t;

   typedef struct {
      exp_t  e;
      int    due;
      string name;
   } item_t;

   item_t expQ[$];
   int    edgeCount = 0;
   int    checks    = 0;
   int    failures  = 0;

   top_cpu #(.WIDTH(8)) dut (
      .clk    (clk),
      .rstn   (rstn),
      .instr  (instr),
      .inA    (inA),
      .inB    (inB),
      .result (result),
      .zero   (zero),
      .neg    (neg),
      .carry  (carry),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model built from the opcode rules using plain integer arithmetic
   function automatic exp_t refModel(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      int   ua, ub, sa, sb, r, sh;
      bit   c, v;
      exp_t e;
      ua = int'(a);
      ub = int'(b);
      sa = (ua > 127) ? ua - 256 : ua;
      sb = (ub > 127) ? ub - 256 : ub;
      sh = ub % 8;
      r  = 0;
      c  = 0;
      v  = 0;
      case (op)
         4'd0: begin r = ua + ub; c = (r > 255); v = ((sa + sb) > 127) || ((sa + sb) < -128); end
         4'd1: begin r = ua - ub; c = (ua < ub); v = ((sa - sb) > 127) || ((sa - sb) < -128); end
         4'd2: r = ua & ub;
         4'd3: r = ua | ub;
         4'd4: r = ua ^ ub;
         4'd5: r = (sa < sb) ? 1 : 0;
         4'd6: r = ua * (1 << sh);
         4'd7: r = ua / (1 << sh);
`ifdef TOP_CPU_SRA_EN
         4'd8: r = sa >>> sh;
`endif
         default: r = 0;
      endcase
      r     = r & 255;
      e.res = 8'(r);
      e.z   = (r == 0);
      e.n   = (r >= 128);
      e.c   = c;
      e.v   = v;
      return e;
   endfunction

   task automatic checkOutput(input string name, input exp_t e);
      exp_t got;
      got = '{res: result, z: zero, n: neg, c: carry, v: ovf};
      checks++;
      if (got !== e) begin
         failures++;
         $display("[TB] FAIL %s: got res=%h z=%b n=%b c=%b v=%b, expected res=%h z=%b n=%b c=%b v=%b",
                  name, got.res, got.z, got.n, got.c, got.v, e.res, e.z, e.n, e.c, e.v);
      end
   endtask

   // Drives one instruction at a negedge and waits one cycle
   task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input string name);
      item_t it;
      instr   = op;
      inA     = a;
      inB     = b;
      it.e    = refModel(op, a, b);
      it.due  = edgeCount + 2;
      it.name = name;
      expQ.push_back(it);
      @(negedge clk);
   endtask

   always @(posedge clk) begin
      edgeCount++;
      #1;
      while (expQ.size() > 0 && expQ[0].due <= edgeCount) begin
         item_t it;
         it = expQ.pop_front();
         checkOutput(it.name, it.e);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      exp_t zeroExp;
      zeroExp = '0;
      rstn  = 1'b1;
      instr = 4'h0;
      inA   = 8'h00;
      inB   = 8'h00;

      repeat (3) @(negedge clk);
      checkOutput("reset_hold", zeroExp);
      rstn = 1'b0;
      repeat (2) @(negedge clk);

      applyStimulus(4'h0, 8'h05, 8'h03, "first_add");
      applyStimulus(4'h0, 8'h7F, 8'h01, "add_ovf");
      applyStimulus(4'h0, 8'hFF, 8'h01, "add_carry");
      applyStimulus(4'h1, 8'h0A, 8'h03, "sub_basic");
      applyStimulus(4'h1, 8'h03, 8'h05, "sub_borrow");
      applyStimulus(4'h1, 8'h80, 8'h01, "sub_ovf");
      applyStimulus(4'h2, 8'hF0, 8'h0F, "and_zero");
      applyStimulus(4'h3, 8'hAA, 8'h55, "or_neg");
      applyStimulus(4'h4, 8'hC3, 8'h3C, "xor");
      applyStimulus(4'h6, 8'h0F, 8'h02, "sll");
      applyStimulus(4'h7, 8'hF0, 8'h03, "srl");
      applyStimulus(4'h6, 8'h81, 8'h0F, "sll_by7");
      applyStimulus(4'h5, 8'h02, 8'h05, "slt_lt");
      applyStimulus(4'h5, 8'h05, 8'h02, "slt_ge");
      applyStimulus(4'h5, 8'h80, 8'h01, "slt_neg");
      applyStimulus(4'hD, 8'hFF, 8'hFF, "illegal");
      applyStimulus(4'h8, 8'h80, 8'h01, "op8");

      for (int i = 0; i < 30; i++) begin
         applyStimulus(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "random_a");
      end

      // Async reset mid-stream: outputs must clear before any clock edge
      #2 rstn = 1'b1;
      #1 checkOutput("async_reset", zeroExp);
      expQ.delete();
      @(negedge clk);
      checkOutput("reset_held_edge", zeroExp);
      rstn = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 30; i++) begin
         applyStimulus(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "random_b");
      end

      for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
      if (expQ.size() > 0) begin
         failures++;
         $display("[TB] FAIL drain: %0d expected results never checked, required 0", expQ.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/top_cpu.md
# top_cpu

Minimal 8-bit CPU core that pairs a two-state control FSM with a registered ALU datapath. Each cycle it executes a 4-bit opcode on two external 8-bit operands and presents a registered result with Z/N/C/V flags. The core is used as the top-level execution unit in the training-CPU series. All behaviour is fully synchronous to one clock, except reset.

## Interface
- WIDTH, 8: datapath width. Only 8 is supported; flag rules below assume bit 7 is the MSB.
- clk  in  1  rising-edge clock.
- rstn  in  1  reset. Asynchronous and active-high: asserted when 1, despite the name.
- instr  in  4  opcode.
- inA  in  8  operand A.
- inB  in  8  operand B.
- result  out  8  registered ALU result.
- zero  out  1  registered; 1 when result == 0.
- neg  out  1  registered; equals result[7].
- carry  out  1  registered carry/borrow.
- ovf  out  1  registered signed overflow.

## Operation
- FSM states:
  - IDLE: entered on reset; the next edge goes to RUN.
  - RUN: self-loop while rstn = 0.
  - No other states.
- In RUN, on every clock edge:
  - Operand stage: op_q <= instr, a_q <= inA, b_q <= inB. This is the load_en strobe.
  - Writeback stage: result, zero, neg, carry and ovf load from the combinational ALU acting on op_q/a_q/b_q. This is the wb_en strobe.
- In IDLE, neither stage loads.
- Opcodes (A = a_q, B = b_q):
  - 0000 ADD: {carry, result} = A + B as a 9-bit sum. ovf = (A[7] == B[7]) && (result[7] != A[7]).
  - 0001 SUB: {carry, result} = A - B as a 9-bit difference, so carry = 1 on unsigned borrow (A < B). ovf = (A[7] != B[7]) && (result[7] != A[7]).
  - 0010 AND; 0011 OR; 0100 XOR.
  - 0101 SLT: result = 8'h01 if $signed(A) < $signed(B), else 8'h00.
  - 0110 SLL: result = A << B[2:0].
  - 0111 SRL: result = A >> B[2:0], logical.
  - 1000–1111: illegal; result = 8'h00.
- carry and ovf are 0 for every opcode other than ADD and SUB.
- zero = (result == 0) and neg = result[7] for every opcode, including illegal ones.
- There is no instruction-valid handshake. Opcode 0000 is a real ADD, so the core executes continuously.

## Timing
- Reset (asynchronous, any time, including mid-operation):
  - FSM -> IDLE.
  - op_q, a_q, b_q cleared to 0.
  - result, zero, neg, carry and ovf all forced to 0 immediately.
- After reset is released:
  - Edge 1: IDLE -> RUN.
  - Edge 2: first operand load.
  - Edge 3: first writeback.
- Steady-state latency: inputs stable before edge N appear on the outputs after edge N+1, a fixed 2 edges.
- Outputs change only on rising edges and hold between edges.
- Inputs changing between edges have no effect until the next edge.
- Back-to-back opcodes are accepted every cycle with throughput 1/cycle. There are no stalls or hazards.

## Configuration
- TOP_CPU_SRA_EN:
  - When defined, opcode 1000 performs an arithmetic shift right: result = $signed(A) >>> B[2:0]. carry = 0, ovf = 0, Z/N per the normal rule.
  - When undefined (default), 1000 is illegal: result = 0, zero = 1, and all other flags 0.
  - No other behaviour differs.

## Test plan
- Reset:
  - Hold rstn = 1 for 3 cycles -> all outputs 0.
  - Assert rstn = 1 asynchronously mid-stream -> outputs drop to 0 without waiting for a clock edge.
  - Release, wait 2 cycles, then apply inA = 05, inB = 03, instr = 0000 -> after 2 edges: result = 08, z = 0, n = 0, c = 0, v = 0.
- ADD/SUB flags:
  - 7F + 01 -> 80, n = 1, v = 1, c = 0.
  - FF + 01 -> 00, z = 1, c = 1.
  - 0A - 03 -> 07, c = 0.
  - 03 - 05 -> FE, c = 1, n = 1.
  - 80 - 01 -> 7F, v = 1.
- Logic and shifts:
  - F0 AND 0F -> 00, z = 1.
  - AA OR 55 -> FF, n = 1.
  - C3 XOR 3C -> FF.
  - 0F SLL 02 -> 3C.
  - F0 SRL 03 -> 1E.
  - 81 SLL 0F (shift amount 7) -> 80.
- SLT signed:
  - 02 vs 05 -> 01.
  - 05 vs 02 -> 00, z = 1.
  - 80 vs 01 -> 01 (-128 < 1).
- Illegal opcode 1101 with A = FF, B = FF -> result 00, z = 1, n = c = v = 0.
- Opcode 1000 with A = 80, B = 01:
  - Macro undefined -> 00, z = 1.
  - With TOP_CPU_SRA_EN -> C0, n = 1.
- Random: 50+ random A/B/opcode (0–15) triples, each checked 2 edges after application against a reference model of the rules above.
